sha1_block_engine: RTL

Iterative SHA-1 compression engine: accepts one 512-bit pre-padded message block, runs the 80-round SHA-1 compression with an in-place 16-word circular message schedule, and returns the 160-bit chaining value. It is the sequential successor to the team's combinational SHA-1 primitives (round functions, rotates, schedule expansion, 32-bit adder). It generalises them with a configurable number of rounds per clock. It sits between the message padder (upstream) and the digest output/host interface (downstream).

---
 rtl/sha1_pkg.sv | 63 ++++++
 rtl/sha1_round.sv | 30 +++
 rtl/sha1_block_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 types, constants and helper functions used by the block engine
// and its combinational round slice.
package sha1_pkg;

  typedef logic [31:0] word_t;

  localparam int RND_W = 7;

  localparam word_t H0 = 32'h67452301;
  localparam word_t H1 = 32'hEFCDAB89;
  localparam word_t H2 = 32'h98BADCFE;
  localparam word_t H3 = 32'h10325476;
  localparam word_t H4 = 32'hC3D2E1F0;

  localparam word_t K0 = 32'h5A827999;
  localparam word_t K1 = 32'h6ED9EBA1;
  localparam word_t K2 = 32'h8F1BBCDC;
  localparam word_t K3 = 32'hCA62C1D6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  function automatic word_t rotl1(input word_t x);
    return {x[30:0], x[31]};
  endfunction

  function automatic word_t rotl5(input word_t x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic word_t rotl30(input word_t x);
    return {x[1:0], x[31:2]};
  endfunction

  function automatic word_t f_sel(input logic [RND_W-1:0] t, input word_t b,
                                  input word_t c, input word_t d);
    if (t < 7'd20) begin
      return (b & c) | (~b & d);
    end else if (t < 7'd40) begin
      return b ^ c ^ d;
    end else if (t < 7'd60) begin
      return (b & c) | (b & d) | (c & d);
    end else begin
      return b ^ c ^ d;
    end
  endfunction

  function automatic word_t k_sel(input logic [RND_W-1:0] t);
    if (t < 7'd20) begin
      return K0;
    end else if (t < 7'd40) begin
      return K1;
    end else if (t < 7'd60) begin
      return K2;
    end else begin
      return K3;
    end
  endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round: consumes a..e, the schedule word and the round
// index, produces the rotated working variables for the next round.
module sha1_round
  import sha1_pkg::*;
(
  input  word_t            a,
  input  word_t            b,
  input  word_t            c,
  input  word_t            d,
  input  word_t            e,
  input  word_t            w,
  input  logic [RND_W-1:0] t,
  output word_t            next_a,
  output word_t            next_b,
  output word_t            next_c,
  output word_t            next_d,
  output word_t            next_e
);

  word_t temp_s;

  assign temp_s = rotl5(a) + f_sel(t, b, c, d) + e + k_sel(t) + w;

  assign next_a = temp_s;
  assign next_b = a;
  assign next_c = rotl30(b);
  assign next_d = c;
  assign next_e = d;

endmodule

// File: rtl/sha1_block_engine.sv
// Iterative SHA-1 compression of one 512-bit padded block, UNROLL rounds per clock.
// Define SHA1_CHAIN_EN to add first_block and chain consecutive blocks of a message.
module sha1_block_engine
  import sha1_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef SHA1_CHAIN_EN
  input  logic         first_block,
`endif
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [159:0] digest
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 5)) begin : g_bad_unroll
      $error("sha1_block_engine: UNROLL must be 1, 2, 4 or 5");
    end
  endgenerate

  localparam logic [RND_W-1:0] STEP = RND_W'(UNROLL);
  localparam logic [RND_W-1:0] LAST = 7'd80;
  localparam word_t IV [5] = '{H0, H1, H2, H3, H4};

  state_t           state_r;
  logic [RND_W-1:0] rnd_r;
  word_t            w_r [16];
  word_t            a_r, b_r, c_r, d_r, e_r;
  word_t            init_s  [5];
  word_t            hbase_s [5];
  logic [159:0]     sum_s;

`ifdef SHA1_CHAIN_EN
  word_t            h_init_r [5];
  word_t            chain_r  [5];

  // Start value and feed-forward base come from the IV or the previous digest.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      if (first_block) begin
        init_s[k] = IV[k];
      end else begin
        init_s[k] = chain_r[k];
      end
      hbase_s[k] = h_init_r[k];
    end
  end
`else
  // Every block starts from the IV.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      init_s[k]  = IV[k];
      hbase_s[k] = IV[k];
    end
  end
`endif

  assign sum_s = {hbase_s[0] + a_r, hbase_s[1] + b_r, hbase_s[2] + c_r,
                  hbase_s[3] + d_r, hbase_s[4] + e_r};

  logic [RND_W-1:0] t_s  [UNROLL];
  word_t            wt_s [UNROLL];
  word_t            ws_s [16];

  // Circular schedule: later rounds in the cycle see words expanded earlier in it.
  always_comb begin
    ws_s = w_r;
    for (int i = 0; i < UNROLL; i++) begin
      t_s[i] = rnd_r + RND_W'(i);
      if (t_s[i] < 7'd16) begin
        wt_s[i] = ws_s[t_s[i][3:0]];
      end else begin
        wt_s[i] = rotl1(ws_s[t_s[i][3:0] + 4'd13] ^ ws_s[t_s[i][3:0] + 4'd8] ^
                        ws_s[t_s[i][3:0] + 4'd2]  ^ ws_s[t_s[i][3:0]]);
        ws_s[t_s[i][3:0]] = wt_s[i];
      end
    end
  end

  word_t sa [UNROLL+1];
  word_t sb [UNROLL+1];
  word_t sc [UNROLL+1];
  word_t sd [UNROLL+1];
  word_t se [UNROLL+1];

  assign sa[0] = a_r;
  assign sb[0] = b_r;
  assign sc[0] = c_r;
  assign sd[0] = d_r;
  assign se[0] = e_r;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    sha1_round u_round (
      .a      (sa[g]),
      .b      (sb[g]),
      .c      (sc[g]),
      .d      (sd[g]),
      .e      (se[g]),
      .w      (wt_s[g]),
      .t      (t_s[g]),
      .next_a (sa[g+1]),
      .next_b (sb[g+1]),
      .next_c (sc[g+1]),
      .next_d (sd[g+1]),
      .next_e (se[g+1])
    );
  end

  // Control FSM, working variables, schedule window and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      rnd_r    <= '0;
      w_r      <= '{default: 32'h0};
      a_r      <= 32'h0;
      b_r      <= 32'h0;
      c_r      <= 32'h0;
      d_r      <= 32'h0;
      e_r      <= 32'h0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      digest   <= 160'h0;
`ifdef SHA1_CHAIN_EN
      h_init_r <= '{H0, H1, H2, H3, H4};
      chain_r  <= '{H0, H1, H2, H3, H4};
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < 16; k++) begin
              w_r[k] <= block_in[511-32*k -: 32];
            end
            a_r      <= init_s[0];
            b_r      <= init_s[1];
            c_r      <= init_s[2];
            d_r      <= init_s[3];
            e_r      <= init_s[4];
`ifdef SHA1_CHAIN_EN
            h_init_r <= init_s;
`endif
            rnd_r    <= '0;
            state_r  <= S_RUN;
            ready    <= 1'b0;
            busy     <= 1'b1;
          end else begin
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          w_r   <= ws_s;
          a_r   <= sa[UNROLL];
          b_r   <= sb[UNROLL];
          c_r   <= sc[UNROLL];
          d_r   <= sd[UNROLL];
          e_r   <= se[UNROLL];
          rnd_r <= rnd_r + STEP;
          if (rnd_r + STEP == LAST) begin
            state_r <= S_FINAL;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_FINAL: begin
          digest  <= sum_s;
          done    <= 1'b1;
          ready   <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
`ifdef SHA1_CHAIN_EN
          for (int k = 0; k < 5; k++) begin
            chain_r[k] <= sum_s[159-32*k -: 32];
          end
`endif
        end
        default: begin
          state_r <= S_IDLE;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
